// File: rtl/tcdm_bank_amo_shim_if.sv
// Bus bundle for tcdm_bank_amo_shim: upstream grant/valid handshake plus
// the master-side signals of one TCDM SRAM bank.
interface tcdm_bank_amo_shim_if #(
  parameter int unsigned AW = 10
);
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  // Upstream request / response
  logic           req_i;
  logic [AW-1:0]  add_i;
  logic           wen_i;
  logic [DW-1:0]  wdata_i;
  logic [BEW-1:0] be_i;
  logic [3:0]     amo_i;
  logic           gnt_o;
  logic           r_valid_o;
  logic [DW-1:0]  r_rdata_o;

  // Bank side
  logic           mem_req_o;
  logic [AW-1:0]  mem_add_o;
  logic           mem_wen_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [BEW-1:0] mem_be_o;
  logic [DW-1:0]  mem_rdata_i;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, amo_i, mem_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o,
    output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, amo_i, mem_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o,
    input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/tcdm_bank_amo_shim.sv
// Bank-side shim: plain TCDM accesses pass through, AMOs run as a locked
// read-modify-write. Define TCDM_AMO_MINMAX_EN to add MAX/MAXU/MIN/MINU.
module tcdm_bank_amo_shim #(
  parameter int unsigned AW = 10
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  tcdm_bank_amo_shim_if.slave bus
);
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_SWAP = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
`ifdef TCDM_AMO_MINMAX_EN
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MAXU = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   operand_q, operand_d;
  logic [3:0]      op_q, op_d;
  logic            r_valid_q, r_valid_d;

  logic            gnt_c;
  logic            mem_req_c;
  logic [AW-1:0]   mem_add_c;
  logic            mem_wen_c;
  logic [DW-1:0]   mem_wdata_c;
  logic [BEW-1:0]  mem_be_c;
  logic [DW-1:0]   amo_result_c;

  // Opcodes outside the implemented set degrade to plain accesses.
  function automatic logic is_amo(input logic [3:0] op);
    logic hit;
    hit = (op >= OP_SWAP) && (op <= OP_XOR);
`ifdef TCDM_AMO_MINMAX_EN
    hit = hit || ((op >= OP_MAX) && (op <= OP_MINU));
`endif
    return hit;
  endfunction

  // Modify step, applied to the word the bank returned for the locked read.
  always_comb begin
    amo_result_c = bus.mem_rdata_i;
    unique case (op_q)
      OP_SWAP: amo_result_c = operand_q;
      OP_ADD:  amo_result_c = bus.mem_rdata_i + operand_q;
      OP_AND:  amo_result_c = bus.mem_rdata_i & operand_q;
      OP_OR:   amo_result_c = bus.mem_rdata_i | operand_q;
      OP_XOR:  amo_result_c = bus.mem_rdata_i ^ operand_q;
`ifdef TCDM_AMO_MINMAX_EN
      OP_MAX:  amo_result_c = ($signed(bus.mem_rdata_i) >= $signed(operand_q)) ? bus.mem_rdata_i : operand_q;
      OP_MAXU: amo_result_c = (bus.mem_rdata_i >= operand_q) ? bus.mem_rdata_i : operand_q;
      OP_MIN:  amo_result_c = ($signed(bus.mem_rdata_i) <= $signed(operand_q)) ? bus.mem_rdata_i : operand_q;
      OP_MINU: amo_result_c = (bus.mem_rdata_i <= operand_q) ? bus.mem_rdata_i : operand_q;
`endif
      default: amo_result_c = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      operand_q <= '0;
      op_q      <= OP_NONE;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      r_valid_q <= r_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    operand_d   = operand_q;
    op_d        = op_q;
    r_valid_d   = 1'b0;
    gnt_c       = 1'b0;
    mem_req_c   = 1'b0;
    mem_add_c   = '0;
    mem_wen_c   = 1'b1;
    mem_wdata_c = '0;
    mem_be_c    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          gnt_c     = 1'b1;
          r_valid_d = 1'b1;
          if (is_amo(bus.amo_i)) begin
            // Locked read; the write-back follows in AMO_WR.
            mem_req_c = 1'b1;
            mem_wen_c = 1'b1;
            mem_add_c = bus.add_i;
            mem_be_c  = {BEW{1'b1}};
            addr_d    = bus.add_i;
            operand_d = bus.wdata_i;
            op_d      = bus.amo_i;
            state_d   = AMO_WR;
          end else begin
            mem_req_c   = 1'b1;
            mem_add_c   = bus.add_i;
            mem_wen_c   = bus.wen_i;
            mem_wdata_c = bus.wdata_i;
            mem_be_c    = bus.be_i;
          end
        end
      end
      AMO_WR: begin
        mem_req_c   = 1'b1;
        mem_wen_c   = 1'b0;
        mem_be_c    = {BEW{1'b1}};
        mem_add_c   = addr_q;
        mem_wdata_c = amo_result_c;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the bank and upstream in the same cycle.
    if (!rst_ni) begin
      gnt_c       = 1'b0;
      mem_req_c   = 1'b0;
      mem_add_c   = '0;
      mem_wen_c   = 1'b1;
      mem_wdata_c = '0;
      mem_be_c    = '0;
    end
  end

  assign bus.gnt_o       = gnt_c;
  assign bus.r_valid_o   = r_valid_q & rst_ni;
  assign bus.r_rdata_o   = (r_valid_q & rst_ni) ? bus.mem_rdata_i : '0;
  assign bus.mem_req_o   = mem_req_c;
  assign bus.mem_add_o   = mem_add_c;
  assign bus.mem_wen_o   = mem_wen_c;
  assign bus.mem_wdata_o = mem_wdata_c;
  assign bus.mem_be_o    = mem_be_c;

endmodule

// File: tb/tb_tcdm_bank_amo_shim.sv
// Bench for tcdm_bank_amo_shim: directed scenarios plus randomized traffic
// checked against a word-level memory/AMO reference model.
module tb_tcdm_bank_amo_shim;
  localparam int unsigned AW = 10;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  tcdm_bank_amo_shim_if #(.AW(AW)) bus ();

  tcdm_bank_amo_shim #(.AW(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM bank stand-in: byte-enabled write, one-cycle registered read.
  logic [31:0] bank [1024];
  logic [31:0] bank_rdata;
  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (!bus.mem_wen_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) bank[bus.mem_add_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bank_rdata <= bank[bus.mem_add_o];
      end
    end
  end
  assign bus.mem_rdata_i = bank_rdata;

  function automatic logic ref_is_amo(input logic [3:0] op);
`ifdef TCDM_AMO_MINMAX_EN
    return (op >= 4'd1) && (op <= 4'd9);
`else
    return (op >= 4'd1) && (op <= 4'd5);
`endif
  endfunction

  function automatic logic [31:0] ref_amo(input logic [3:0] op, input logic [31:0] old, input logic [31:0] b);
    case (op)
      4'd1: return b;
      4'd2: return old + b;
      4'd3: return old & b;
      4'd4: return old | b;
      4'd5: return old ^ b;
      4'd6: return ($signed(old) >= $signed(b)) ? old : b;
      4'd7: return (old >= b) ? old : b;
      4'd8: return ($signed(old) <= $signed(b)) ? old : b;
      4'd9: return (old <= b) ? old : b;
      default: return old;
    endcase
  endfunction

  task automatic set_req(input logic req, input logic [AW-1:0] add, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] amo);
    bus.req_i   = req;
    bus.add_i   = add;
    bus.wen_i   = wen;
    bus.wdata_i = wdata;
    bus.be_i    = be;
    bus.amo_i   = amo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b1, 10'd4, 1'b0, 32'h1234_5678, 4'hF, 4'd0);
    tick();
    @(negedge clk);
    vectors++;
    if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
    vectors++;
    if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); end
    vectors++;
    if (bus.r_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b expected 0", bus.r_valid_o); end
    vectors++;
    if (bus.mem_wen_o !== 1'b1) begin miscompares++; $display("FAIL reset_mem_wen: got %b expected 1", bus.mem_wen_o); end
    tick();
    rst_n = 1'b1;
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if ({bus.mem_add_o, bus.mem_wdata_o, bus.mem_be_o, bus.r_rdata_o, bus.mem_wen_o} !== {10'd0, 32'd0, 4'd0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL idle_outputs: got add=%h wdata=%h be=%h rdata=%h wen=%b expected zeros with wen=1",
               bus.mem_add_o, bus.mem_wdata_o, bus.mem_be_o, bus.r_rdata_o, bus.mem_wen_o);
    end
    tick();
  endtask

  task automatic test_plain();
    set_req(1'b1, 10'd5, 1'b0, 32'hDEAD_BEEF, 4'hF, 4'd0);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.mem_req_o, bus.mem_wen_o, bus.mem_add_o, bus.mem_wdata_o} !== {1'b1, 1'b1, 1'b0, 10'd5, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL plain_write: got gnt=%b req=%b wen=%b add=%h wdata=%h expected 1 1 0 005 deadbeef",
               bus.gnt_o, bus.mem_req_o, bus.mem_wen_o, bus.mem_add_o, bus.mem_wdata_o);
    end
    tick();
    set_req(1'b1, 10'd5, 1'b1, 32'h0, 4'hF, 4'd0);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.r_valid_o} !== 2'b11) begin miscompares++; $display("FAIL plain_read_gnt: got gnt=%b r_valid=%b expected 1 1", bus.gnt_o, bus.r_valid_o); end
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if ({bus.r_valid_o, bus.r_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL plain_read_data: got valid=%b data=%h expected 1 deadbeef", bus.r_valid_o, bus.r_rdata_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.r_valid_o !== 1'b0) begin miscompares++; $display("FAIL idle_r_valid: got %b expected 0", bus.r_valid_o); end
    tick();
  endtask

  task automatic test_byte_write();
    set_req(1'b1, 10'd3, 1'b0, 32'h1122_3344, 4'hF, 4'd0);
    tick();
    set_req(1'b1, 10'd3, 1'b0, 32'hAABB_CCDD, 4'b0101, 4'd0);
    tick();
    set_req(1'b1, 10'd3, 1'b1, 32'h0, 4'hF, 4'd0);
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'h11BB_33DD) begin miscompares++; $display("FAIL byte_write: got %h expected 11bb33dd", bus.r_rdata_o); end
    tick();
  endtask

  task automatic test_amo_add_wrap();
    set_req(1'b1, 10'd7, 1'b0, 32'hFFFF_FFFF, 4'hF, 4'd0);
    tick();
    set_req(1'b1, 10'd7, 1'b1, 32'd2, 4'h0, 4'd2);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.mem_req_o, bus.mem_wen_o, bus.mem_add_o} !== {1'b1, 1'b1, 1'b1, 10'd7}) begin
      miscompares++; $display("FAIL amo_read_phase: got gnt=%b req=%b wen=%b add=%h expected 1 1 1 007",
                              bus.gnt_o, bus.mem_req_o, bus.mem_wen_o, bus.mem_add_o);
    end
    tick();
    set_req(1'b1, 10'd7, 1'b1, 32'h0, 4'hF, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.gnt_o !== 1'b0) begin miscompares++; $display("FAIL amo_wr_gnt: got %b expected 0", bus.gnt_o); end
    vectors++;
    if ({bus.r_valid_o, bus.r_rdata_o} !== {1'b1, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL amo_add_resp: got valid=%b data=%h expected 1 ffffffff", bus.r_valid_o, bus.r_rdata_o);
    end
    vectors++;
    if ({bus.mem_req_o, bus.mem_wen_o, bus.mem_be_o, bus.mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h1}) begin
      miscompares++; $display("FAIL amo_wr_phase: got req=%b wen=%b be=%h wdata=%h expected 1 0 f 00000001",
                              bus.mem_req_o, bus.mem_wen_o, bus.mem_be_o, bus.mem_wdata_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.r_valid_o} !== 2'b10) begin miscompares++; $display("FAIL held_read_gnt: got gnt=%b r_valid=%b expected 1 0", bus.gnt_o, bus.r_valid_o); end
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL amo_add_wrap: got %h expected 00000001", bus.r_rdata_o); end
    tick();
  endtask

  task automatic test_minmax();
    set_req(1'b1, 10'd0, 1'b0, 32'hFFFF_FFFE, 4'hF, 4'd0);
    tick();
`ifdef TCDM_AMO_MINMAX_EN
    set_req(1'b1, 10'd0, 1'b1, 32'd1, 4'hF, 4'd8);
    tick();
    set_req(1'b1, 10'd0, 1'b1, 32'd0, 4'hF, 4'd0);
    tick();
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL amo_min: got %h expected fffffffe", bus.r_rdata_o); end
    tick();
    set_req(1'b1, 10'd0, 1'b1, 32'd1, 4'hF, 4'd9);
    tick();
    set_req(1'b1, 10'd0, 1'b1, 32'd0, 4'hF, 4'd0);
    tick();
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL amo_minu: got %h expected 00000001", bus.r_rdata_o); end
    tick();
`else
    set_req(1'b1, 10'd0, 1'b1, 32'd1, 4'hF, 4'd8);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.mem_wen_o} !== 2'b11) begin miscompares++; $display("FAIL op8_plain_read: got gnt=%b wen=%b expected 1 1", bus.gnt_o, bus.mem_wen_o); end
    tick();
    set_req(1'b1, 10'd0, 1'b1, 32'd0, 4'hF, 4'd0);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.r_rdata_o} !== {1'b1, 32'hFFFF_FFFE}) begin
      miscompares++; $display("FAIL op8_no_block: got gnt=%b data=%h expected 1 fffffffe", bus.gnt_o, bus.r_rdata_o);
    end
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL op8_mem_unchanged: got %h expected fffffffe", bus.r_rdata_o); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_amo();
    set_req(1'b1, 10'd9, 1'b0, 32'h5, 4'hF, 4'd0);
    tick();
    set_req(1'b1, 10'd9, 1'b1, 32'hA, 4'hF, 4'd1);
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_amo_req: got %b expected 0", bus.mem_req_o); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.r_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_amo_valid: got %b expected 0", bus.r_valid_o); end
    tick();
    set_req(1'b1, 10'd9, 1'b1, 32'h0, 4'hF, 4'd0);
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'h5) begin miscompares++; $display("FAIL rst_mid_amo_mem: got %h expected 00000005", bus.r_rdata_o); end
    tick();
  endtask

  task automatic test_illegal_opcode();
    set_req(1'b1, 10'd2, 1'b0, 32'h7, 4'hF, 4'hC);
    @(negedge clk);
    vectors++;
    if ({bus.gnt_o, bus.mem_wen_o, bus.mem_wdata_o} !== {1'b1, 1'b0, 32'h7}) begin
      miscompares++; $display("FAIL illegal_op_write: got gnt=%b wen=%b wdata=%h expected 1 0 00000007", bus.gnt_o, bus.mem_wen_o, bus.mem_wdata_o);
    end
    tick();
    set_req(1'b1, 10'd2, 1'b1, 32'h0, 4'hF, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.gnt_o !== 1'b1) begin miscompares++; $display("FAIL illegal_op_next_gnt: got %b expected 1", bus.gnt_o); end
    tick();
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    @(negedge clk);
    vectors++;
    if (bus.r_rdata_o !== 32'h7) begin miscompares++; $display("FAIL illegal_op_data: got %h expected 00000007", bus.r_rdata_o); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [8];
    logic        req, wen, hold, blocked, exp_gnt, exp_valid, exp_chk;
    logic        nxt_valid, nxt_chk;
    logic [2:0]  idx;
    logic [31:0] wdata, exp_data, nxt_data;
    logic [3:0]  be, amo;

    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      set_req(1'b1, AW'(16 + i), 1'b0, ref_mem[i], 4'hF, 4'd0);
      tick();
    end
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    tick();
    tick();

    hold = 1'b0; blocked = 1'b0; exp_valid = 1'b0; exp_chk = 1'b0; exp_data = '0;
    req = 1'b0; wen = 1'b1; idx = '0; wdata = '0; be = '0; amo = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        req   = ($urandom_range(0, 3) != 0);
        idx   = 3'($urandom_range(0, 7));
        wen   = 1'($urandom);
        wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
        be    = 4'($urandom);
        amo   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      set_req(req, AW'(16) + AW'(idx), wen, wdata, be, amo);
      exp_gnt = req && !blocked;
      @(negedge clk);
      vectors++;
      if (bus.gnt_o !== exp_gnt) begin miscompares++; $display("FAIL rand_gnt[%0d]: got %b expected %b", n, bus.gnt_o, exp_gnt); end
      vectors++;
      if (bus.r_valid_o !== exp_valid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, bus.r_valid_o, exp_valid); end
      if (exp_valid && exp_chk) begin
        vectors++;
        if (bus.r_rdata_o !== exp_data) begin miscompares++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, bus.r_rdata_o, exp_data); end
      end

      nxt_valid = exp_gnt; nxt_chk = 1'b0; nxt_data = '0;
      if (exp_gnt) begin
        if (ref_is_amo(amo)) begin
          nxt_chk = 1'b1; nxt_data = ref_mem[idx];
          ref_mem[idx] = ref_amo(amo, ref_mem[idx], wdata);
        end else if (wen) begin
          nxt_chk = 1'b1; nxt_data = ref_mem[idx];
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      blocked   = exp_gnt && ref_is_amo(amo);
      hold      = req && !exp_gnt;
      exp_valid = nxt_valid; exp_chk = nxt_chk; exp_data = nxt_data;
      tick();
    end
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    tick();
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    set_req(1'b0, '0, 1'b1, '0, '0, 4'd0);
    test_reset();
    test_plain();
    test_byte_write();
    test_amo_add_wrap();
    test_minmax();
    test_reset_mid_amo();
    test_illegal_opcode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_amo_shim.md
Name: tcdm_bank_amo_shim

Overview:
- Bank-side stage sitting directly upstream of one TCDM SRAM bank; its memory-side ports drive the bank's master-side signals (wdata, add, req, wen, be; rdata returned one cycle later).
- Passes plain loads and stores straight through with one cycle of read latency.
- Executes atomic memory operations (AMOs) as an indivisible read-modify-write in the bank, so the cluster interconnect needs no atomics support.
- Upstream side is a grant/valid handshake from the interconnect.

Parameters:
- AW, 10, bank word-address width.
- DW, 32, data width; fixed at 32, since the bank bus is 32-bit with 4 byte enables.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  1  upstream request.
- add_i  in  AW  bank word address.
- wen_i  in  1  1 = read, 0 = write.
- wdata_i  in  32  write data / AMO operand.
- be_i  in  4  byte enables, active-high.
- amo_i  in  4  AMO opcode.
- gnt_o  out  1  request accepted this cycle.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  32  response data.
- mem_req_o  out  1  bank request.
- mem_add_o  out  AW  bank address.
- mem_wen_o  out  1  bank write-enable, 1 = read.
- mem_wdata_o  out  32  bank write data.
- mem_be_o  out  4  bank byte enables.
- mem_rdata_i  in  32  bank read data, valid the cycle after a read request.

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Reset state: IDLE, r_valid_o=0, mem_req_o=0.
  - r_rdata_o, mem_add_o, mem_wdata_o, mem_be_o are 0 while idle.
  - mem_wen_o=1 while idle.
- AMO opcodes:
  - 0 NONE, 1 SWAP, 2 ADD, 3 AND, 4 OR, 5 XOR, 6 MAX, 7 MAXU, 8 MIN, 9 MINU.
  - Codes 10-15 are treated as NONE.
- FSM states: IDLE, AMO_WR.
- IDLE:
  - gnt_o = req_i, combinational.
  - If req_i and amo_i is NONE: mem_* = upstream fields, combinational pass-through.
  - If req_i and amo_i is an AMO: mem_req_o=1, mem_wen_o=1, mem_add_o=add_i.
    - Register add_i, wdata_i and amo_i.
    - Next state AMO_WR.
    - wen_i and be_i are ignored.
- AMO_WR (exactly one cycle):
  - gnt_o=0 regardless of req_i.
  - old = mem_rdata_i.
  - Drive mem_req_o=1, mem_wen_o=0, mem_be_o=4'hF, mem_add_o=saved address, mem_wdata_o=f(old, operand).
  - Next state IDLE.
- AMO function f, always a full 32-bit word:
  - ADD: wraps modulo 2^32; carry discarded.
  - MAX/MIN: signed two's-complement compare.
  - MAXU/MINU: unsigned compare.
  - Equal operands: result = old.
- Response:
  - Every granted request (read, write or AMO) sets r_valid_o=1 exactly one cycle later; r_valid_o=0 otherwise.
  - r_rdata_o = mem_rdata_i in that cycle. Reads and AMOs return the pre-modification word; for writes the data is don't-care.
- Throughput:
  - Plain accesses: back-to-back, one per cycle.
  - An AMO blocks the following cycle; the next grant is possible two cycles after the AMO grant.
- Request ordering:
  - A request in the AMO_WR cycle is simply not granted.
  - The requester holds it, and it is granted in the following IDLE cycle.
- Reset behaviour:
  - Reset asserted in AMO_WR: the write is suppressed (mem_req_o=0 that cycle), the state returns to IDLE and the pending r_valid is cleared.
  - Reset asserted with req_i high: gnt_o=0 while rst_ni=0.

Optional Feature:
- Macro: TCDM_AMO_MINMAX_EN.
- Defined: opcodes 6-9 are implemented as above.
- Undefined:
  - Opcodes 6-9 are treated as NONE: the request is a plain access using wen_i and be_i, with no read-modify-write.
  - No comparator logic is synthesised.

Test Plan:
- Plain path: write 32'hDEADBEEF to addr 5 with be=4'hF, then read addr 5 in the next cycle. Required: gnt_o=1 both cycles, and r_valid_o=1 with r_rdata_o=32'hDEADBEEF one cycle after the read.
- Byte write: preload addr 3 with 32'h11223344, write 32'hAABBCCDD with be=4'b0101, then read. Required: read returns 32'h11BB33DD.
- AMO ADD wrap: addr 7 holds 32'hFFFFFFFF; AMO ADD with operand 2, with req_i held high for a following read of addr 7. Required:
  - The AMO response is 32'hFFFFFFFF.
  - gnt_o=0 in the AMO_WR cycle.
  - The read is granted one cycle later and returns 32'h00000001.
- MIN/MINU (macro defined): addr 0 holds 32'hFFFFFFFE.
  - AMO MIN with operand 1 leaves 32'hFFFFFFFE.
  - AMO MINU with operand 1 leaves 32'h00000001.
  - With the macro undefined and wen_i=1, opcode 8 is a plain read and memory is unchanged.
- Reset mid-AMO: addr 9 holds 32'h5; issue AMO SWAP with operand 32'hA and assert rst_ni=0 in the AMO_WR cycle. Required: mem_req_o=0 in that cycle, r_valid_o=0 after reset, and addr 9 still reads 32'h5.
- Illegal opcode: amo_i=4'hC with a write of 32'h7 to addr 2. Required: performed as a plain write with single-cycle grant, and gnt_o stays high for the next request.
